// File: rtl/rr_arbiter4to1.sv
// +--------------------------------------------------------------------------+
// | rr_arbiter4to1 : 4-source round-robin arbiter with burst locking and a   |
// | one-entry registered output stage. Optional lock timeout: ARB_TIMEOUT_EN |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module rr_arbiter4to1 #(
  parameter int DATA_W       = 32,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [3:0]        i_req,
  input  logic [3:0]        i_last,
  input  logic [DATA_W-1:0] i_data_00,
  input  logic [DATA_W-1:0] i_data_01,
  input  logic [DATA_W-1:0] i_data_10,
  input  logic [DATA_W-1:0] i_data_11,
  output logic [3:0]        o_gnt,
  output logic [1:0]        o_sel,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_src,
  output logic              o_last,
  input  logic              i_ready,
  output logic              o_timeout
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t            r_state;
  logic [1:0]        r_ptr;
  logic [1:0]        r_owner;

  logic              w_free;
  logic              w_found;
  logic [1:0]        w_win;
  logic [1:0]        w_idx;
  logic [3:0]        w_gnt;
  logic              w_acc;
  logic              w_beat_last;
  logic [DATA_W-1:0] w_data;
  logic              w_tmo_hit;

  if (LOCK_TIMEOUT < 1 || LOCK_TIMEOUT > 255) begin : g_bad_timeout
    $error("rr_arbiter4to1: LOCK_TIMEOUT must be in 1..255");
  end

  assign w_free = !o_valid || i_ready;

  // Scan requests starting at the pointer; first hit wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_idx   = r_ptr;
    for (int k = 0; k < 4; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_found && i_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_gnt = 4'b0000;
    o_sel = (r_state == ST_LOCKED) ? r_owner : w_win;
    if (i_rst_n && w_free) begin
      if (r_state == ST_LOCKED) begin
        w_gnt[r_owner] = i_req[r_owner];
      end else if (w_found) begin
        w_gnt[w_win] = 1'b1;
      end
    end
  end

  assign o_gnt       = w_gnt;
  assign w_acc       = |w_gnt;
  assign w_beat_last = i_last[o_sel];

  always_comb begin
    case (o_sel)
      2'd0:    w_data = i_data_00;
      2'd1:    w_data = i_data_01;
      2'd2:    w_data = i_data_10;
      default: w_data = i_data_11;
    endcase
  end

  // Output stage: refill takes priority over drain so there is no bubble.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_src   <= 2'd0;
      o_last  <= 1'b0;
    end else if (w_acc) begin
      o_valid <= 1'b1;
      o_data  <= w_data;
      o_src   <= o_sel;
      o_last  <= w_beat_last;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= 2'd0;
      r_owner <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            if (w_beat_last) begin
              r_ptr <= o_sel + 2'd1;
            end else begin
              r_state <= ST_LOCKED;
              r_owner <= o_sel;
            end
          end
        end
        default: begin
          if ((w_acc && w_beat_last) || w_tmo_hit) begin
            r_state <= ST_IDLE;
            r_ptr   <= r_owner + 2'd1;
          end
        end
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] c_tmo = 8'(LOCK_TIMEOUT);

  logic [7:0] r_cnt;
  logic       r_timeout;

  // Hit on the idle cycle that would bring the count up to the limit.
  assign w_tmo_hit = (r_state == ST_LOCKED) && !i_req[r_owner] &&
                     (8'(r_cnt + 8'd1) == c_tmo);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_tmo_hit;
      if (r_state != ST_LOCKED || i_req[r_owner] || w_tmo_hit) begin
        r_cnt <= 8'd0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign o_timeout = r_timeout;
`else
  assign w_tmo_hit = 1'b0;
  assign o_timeout = 1'b0;
`endif

endmodule

`default_nettype wire
